// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned IDX_W_DEFAULT = 5;
  localparam int unsigned DIV_CNT_W     = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Encoded value doubles as priority rank: larger value wins.
  typedef enum logic [2:0] {
    SRC_NONE     = 3'd0,
    SRC_LOAD_USE = 3'd1,
    SRC_REDIRECT = 3'd2,
    SRC_DIVIDE   = 3'd3,
    SRC_MEM      = 3'd4
  } hazard_src_e;

  typedef struct packed {
    logic pc_hold;
    logic id_hold;
    logic ex_hold;
    logic mem_hold;
    logic ex_stall_n;
    logic mem_stall_n;
    logic wb_stall_n;
    logic id_flush;
    logic ex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_IDLE = '{
    pc_hold: 1'b0, id_hold: 1'b0, ex_hold: 1'b0, mem_hold: 1'b0,
    ex_stall_n: 1'b1, mem_stall_n: 1'b1, wb_stall_n: 1'b1,
    id_flush: 1'b0, ex_flush: 1'b0
  };

  function automatic pipe_ctrl_t ctrl_for_src(hazard_src_e src);
    pipe_ctrl_t c;
    c = CTRL_IDLE;
    case (src)
      SRC_MEM: begin
        c.pc_hold    = 1'b1;
        c.id_hold    = 1'b1;
        c.ex_hold    = 1'b1;
        c.mem_hold   = 1'b1;
        c.wb_stall_n = 1'b0;
      end
      SRC_DIVIDE: begin
        c.pc_hold     = 1'b1;
        c.id_hold     = 1'b1;
        c.ex_hold     = 1'b1;
        c.mem_stall_n = 1'b0;
      end
      SRC_REDIRECT: begin
        c.id_flush = 1'b1;
        c.ex_flush = 1'b1;
      end
      SRC_LOAD_USE: begin
        c.pc_hold    = 1'b1;
        c.id_hold    = 1'b1;
        c.ex_stall_n = 1'b0;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEFAULT
) (
  input  logic [IDX_W-1:0] id_rs1_idx_i,
  input  logic [IDX_W-1:0] id_rs2_idx_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [IDX_W-1:0] ex_rd_idx_i,
  input  logic             ex_is_load_i,
  input  logic             ex_wben_i,
  output logic             hazard_o
);

  logic rs1_match, rs2_match;

  assign rs1_match = id_rs1_used_i && (id_rs1_idx_i == ex_rd_idx_i);
  assign rs2_match = id_rs2_used_i && (id_rs2_idx_i == ex_rd_idx_i);

  // x0 is hard-wired zero, so a load targeting it never produces a dependency.
  assign hazard_o = ex_is_load_i && ex_wben_i && (ex_rd_idx_i != '0)
                    && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: prioritises LSU back-pressure, divide,
// redirect and load-use hazards, and runs the divider start handshake.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W       = IDX_W_DEFAULT,
  parameter int unsigned DIV_TIMEOUT = 100,
  parameter int unsigned CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] id_rs1_idx,
  input  logic [IDX_W-1:0] id_rs2_idx,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [IDX_W-1:0] ex_rd_idx,
  input  logic             ex_is_load,
  input  logic             ex_wben,
  input  logic             ex_div_en,
  input  logic             div_done,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             id_hold,
  output logic             ex_hold,
  output logic             mem_hold,
  output logic             ex_stall_n,
  output logic             mem_stall_n,
  output logic             wb_stall_n,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             div_start,
  output logic             div_busy,
  output logic             div_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [DIV_CNT_W-1:0] DIV_LIMIT = DIV_CNT_W'(DIV_TIMEOUT);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic                 div_timeout_q, div_timeout_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic        lu_hazard;
  logic        start_ok;
  logic        div_hold;
  hazard_src_e src;
  pipe_ctrl_t  ctrl;

  load_use_detect #(.IDX_W(IDX_W)) u_load_use (
    .id_rs1_idx_i (id_rs1_idx),
    .id_rs2_idx_i (id_rs2_idx),
    .id_rs1_used_i(id_rs1_used),
    .id_rs2_used_i(id_rs2_used),
    .ex_rd_idx_i  (ex_rd_idx),
    .ex_is_load_i (ex_is_load),
    .ex_wben_i    (ex_wben),
    .hazard_o     (lu_hazard)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    div_timeout_d = div_timeout_q;
    start_ok      = 1'b0;
    div_hold      = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (ex_div_en && !mem_busy) begin
          start_ok  = 1'b1;
          div_hold  = 1'b1;
          div_cnt_d = '0;
          state_d   = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        div_hold = 1'b1;
        if (div_cnt_q != '1) begin
          div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        end
        if (div_cnt_d == DIV_LIMIT) begin
          div_timeout_d = 1'b1;
        end
        if (div_done) begin
          state_d = DIV_DONE;
        end
      end
      // ex_div_en is ignored here so the finishing divide is not restarted.
      DIV_DONE: begin
        if (!mem_busy) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    src = SRC_NONE;
    if (rst) begin
      src = SRC_NONE;
    end else if (mem_busy) begin
      src = SRC_MEM;
    end else if (div_hold) begin
      src = SRC_DIVIDE;
    end else if (ex_redirect) begin
      src = SRC_REDIRECT;
    end else if (lu_hazard) begin
      src = SRC_LOAD_USE;
    end
    ctrl        = ctrl_for_src(src);
    stall_cnt_d = stall_cnt_q + CNT_W'(ctrl.pc_hold);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    if (rst) begin
      state_q       <= DIV_IDLE;
      div_cnt_q     <= '0;
      div_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      div_timeout_q <= div_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign pc_hold      = ctrl.pc_hold;
  assign id_hold      = ctrl.id_hold;
  assign ex_hold      = ctrl.ex_hold;
  assign mem_hold     = ctrl.mem_hold;
  assign ex_stall_n   = ctrl.ex_stall_n;
  assign mem_stall_n  = ctrl.mem_stall_n;
  assign wb_stall_n   = ctrl.wb_stall_n;
  assign id_flush     = ctrl.id_flush;
  assign ex_flush     = ctrl.ex_flush;
  assign div_start    = start_ok && !rst;
  assign div_busy     = (state_q != DIV_IDLE);
  assign div_timeout  = div_timeout_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int IDX_W       = 5;
  localparam int DIV_TIMEOUT = 100;
  localparam int CNT_W       = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [IDX_W-1:0] id_rs1_idx, id_rs2_idx, ex_rd_idx;
  logic             id_rs1_used, id_rs2_used;
  logic             ex_is_load, ex_wben, ex_div_en, div_done, ex_redirect, mem_busy;
  logic             pc_hold, id_hold, ex_hold, mem_hold;
  logic             ex_stall_n, mem_stall_n, wb_stall_n;
  logic             id_flush, ex_flush, div_start, div_busy, div_timeout;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: a divide in flight, a finished divide waiting for EX to
  // move on, BUSY cycles seen, sticky timeout and the stall tally.
  bit          m_op, m_wait, m_to;
  int          m_busy_n;
  logic [63:0] m_stall;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.IDX_W(IDX_W), .DIV_TIMEOUT(DIV_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_idx(ex_rd_idx), .ex_is_load(ex_is_load), .ex_wben(ex_wben),
    .ex_div_en(ex_div_en), .div_done(div_done), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy),
    .pc_hold(pc_hold), .id_hold(id_hold), .ex_hold(ex_hold), .mem_hold(mem_hold),
    .ex_stall_n(ex_stall_n), .mem_stall_n(mem_stall_n), .wb_stall_n(wb_stall_n),
    .id_flush(id_flush), .ex_flush(ex_flush),
    .div_start(div_start), .div_busy(div_busy), .div_timeout(div_timeout),
    .stall_cycles(stall_cycles)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs1_idx = '0; id_rs2_idx = '0; ex_rd_idx = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_is_load = 1'b0; ex_wben = 1'b0; ex_div_en = 1'b0;
    div_done = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  // Compare process: derive the expected controls from the rules, check,
  // then advance the model as the coming clock edge will.
  always @(negedge clk) begin
    if (chk_en) begin
      bit lu, start, div_act;
      bit e_pc, e_id, e_ex, e_mem, e_exs, e_mems, e_wbs, e_idf, e_exf;
      lu = ex_is_load && ex_wben && (ex_rd_idx != 0) &&
           ((id_rs1_used && id_rs1_idx == ex_rd_idx) ||
            (id_rs2_used && id_rs2_idx == ex_rd_idx));
      start   = !rst && !m_op && !m_wait && ex_div_en && !mem_busy;
      div_act = m_op || start;
      {e_pc, e_id, e_ex, e_mem, e_idf, e_exf} = '0;
      {e_exs, e_mems, e_wbs} = 3'b111;
      if (rst) begin
      end else if (mem_busy) begin
        {e_pc, e_id, e_ex, e_mem} = 4'b1111;
        e_wbs = 1'b0;
      end else if (div_act) begin
        {e_pc, e_id, e_ex} = 3'b111;
        e_mems = 1'b0;
      end else if (ex_redirect) begin
        {e_idf, e_exf} = 2'b11;
      end else if (lu) begin
        {e_pc, e_id} = 2'b11;
        e_exs = 1'b0;
      end
      check("pc_hold", pc_hold, e_pc);
      check("id_hold", id_hold, e_id);
      check("ex_hold", ex_hold, e_ex);
      check("mem_hold", mem_hold, e_mem);
      check("ex_stall_n", ex_stall_n, e_exs);
      check("mem_stall_n", mem_stall_n, e_mems);
      check("wb_stall_n", wb_stall_n, e_wbs);
      check("id_flush", id_flush, e_idf);
      check("ex_flush", ex_flush, e_exf);
      check("div_start", div_start, start);
      check("div_busy", div_busy, m_op || m_wait);
      check("div_timeout", div_timeout, m_to);
      check("stall_cycles", stall_cycles, m_stall);
      if (rst) begin
        m_op = 0; m_wait = 0; m_to = 0; m_busy_n = 0; m_stall = '0;
      end else begin
        if (start) begin
          m_op = 1; m_busy_n = 0;
        end else if (m_op) begin
          if (m_busy_n < 255) m_busy_n++;
          if (m_busy_n == DIV_TIMEOUT) m_to = 1;
          if (div_done) begin
            m_op = 0; m_wait = 1;
          end
        end else if (m_wait && !mem_busy) begin
          m_wait = 0;
        end
        m_stall = m_stall + 64'(e_pc);
      end
    end
  end

  initial begin
    int starts, holds, done_cyc, wb_low;
    clear_inputs();
    rst = 1'b1;
    next();
    chk_en = 1'b1;
    next();
    rst = 1'b0;
    mid();
    check("reset_pc_hold", pc_hold, 0);
    check("reset_wb_stall_n", wb_stall_n, 1);
    check("reset_stall_cycles", stall_cycles, 0);
    check("reset_div_busy", div_busy, 0);

    // Load x5 in EX, ID reads x5: one-cycle hold, then released.
    next();
    ex_is_load = 1; ex_wben = 1; ex_rd_idx = 5; id_rs1_idx = 5; id_rs1_used = 1;
    mid();
    check("lu_pc_hold", pc_hold, 1);
    check("lu_id_hold", id_hold, 1);
    check("lu_ex_stall_n", ex_stall_n, 0);
    next();
    ex_is_load = 0;
    mid();
    check("lu_released", pc_hold, 0);
    next();
    ex_is_load = 1; ex_rd_idx = 0; id_rs1_idx = 0;
    mid();
    check("lu_x0_no_stall", pc_hold, 0);
    check("lu_x0_ex_stall_n", ex_stall_n, 1);

    // Redirect beats a simultaneous load-use hazard.
    next();
    ex_rd_idx = 5; id_rs1_idx = 5; ex_redirect = 1;
    mid();
    check("redir_id_flush", id_flush, 1);
    check("redir_ex_flush", ex_flush, 1);
    check("redir_pc_hold", pc_hold, 0);
    next();
    clear_inputs();

    // Divide with div_done arriving 8 cycles after the start pulse.
    rst = 1; next(); rst = 0;
    starts = 0; holds = 0;
    for (int c = 0; c <= 10; c++) begin
      ex_div_en = (c <= 9);
      div_done  = (c >= 8);
      mid();
      starts += int'(div_start);
      holds  += int'(pc_hold);
      if (c == 0) check("div_start_pulse", div_start, 1);
      if (c == 9) check("div_done_no_hold", pc_hold, 0);
      if (c == 9) check("div_done_busy", div_busy, 1);
      if (c == 10) check("div_back_idle", div_busy, 0);
      next();
    end
    clear_inputs();
    mid();
    check("div_start_count", 64'(starts), 1);
    check("div_hold_cycles", 64'(holds), 9);
    check("div_stall_cycles", stall_cycles, 9);
    next();

    // mem_busy for 3 cycles while the result sits in DIV_DONE.
    rst = 1; next(); rst = 0;
    starts = 0; done_cyc = 0; wb_low = 0;
    for (int c = 0; c <= 7; c++) begin
      ex_div_en = (c <= 6);
      div_done  = (c >= 2);
      mem_busy  = (c >= 3 && c <= 5);
      mid();
      starts += int'(div_start);
      if (c >= 3 && div_busy) done_cyc++;
      if (!wb_stall_n) wb_low++;
      next();
    end
    clear_inputs();
    check("done_mb_starts", 64'(starts), 1);
    check("done_mb_cycles", 64'(done_cyc), 4);
    check("done_mb_wb_low", 64'(wb_low), 3);

    // div_done withheld: timeout after DIV_TIMEOUT BUSY cycles, sticky.
    rst = 1; next(); rst = 0;
    ex_div_en = 1;
    for (int c = 0; c <= 105; c++) begin
      mid();
      if (c == DIV_TIMEOUT) check("timeout_not_yet", div_timeout, 0);
      if (c == DIV_TIMEOUT + 1) check("timeout_set", div_timeout, 1);
      next();
    end
    div_done = 1; next(); next();
    clear_inputs();
    mid();
    check("timeout_sticky", div_timeout, 1);
    next();
    rst = 1; next(); rst = 0;
    mid();
    check("rst_timeout_clr", div_timeout, 0);
    check("rst_stall_clr", stall_cycles, 0);
    check("rst_div_idle", div_busy, 0);

    // Reset in the middle of a divide, divide request still present.
    next();
    ex_div_en = 1;
    next(); next(); next();
    rst = 1;
    mid();
    check("rst_no_start", div_start, 0);
    next();
    rst = 0;
    mid();
    check("post_rst_start", div_start, 1);
    next();
    div_done = 1; next();
    clear_inputs(); next();

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      id_rs1_idx  = IDX_W'($urandom_range(0, 3));
      id_rs2_idx  = IDX_W'($urandom_range(0, 3));
      ex_rd_idx   = IDX_W'($urandom_range(0, 3));
      id_rs1_used = ($urandom_range(0, 1) == 1);
      id_rs2_used = ($urandom_range(0, 1) == 1);
      ex_is_load  = ($urandom_range(0, 1) == 1);
      ex_wben     = ($urandom_range(0, 3) != 0);
      ex_div_en   = ($urandom_range(0, 6) == 0);
      div_done    = ($urandom_range(0, 4) == 0);
      ex_redirect = ($urandom_range(0, 6) == 0);
      mem_busy    = ($urandom_range(0, 4) == 0);
      next();
    end
    clear_inputs();
    next();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline: IF, ID/EX reg, EX/MEM reg, MEM/WB reg.
- Produces per-register hold, bubble and flush controls from four sources: load-use hazards, multi-cycle divide sequencing, EX-stage redirects and LSU back-pressure.
- Owns the divider start handshake.
- Bubble outputs drive the active-low stall_n inputs of the stage registers; low inserts a zeroed NOP.

Parameters:
- IDX_W, 5, register index width
- DIV_TIMEOUT, 100, DIV_BUSY cycles after which div_timeout is set
- CNT_W, 64, performance counter width

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- id_rs1_idx, id_rs2_idx  in  IDX_W  source indices of the instruction in ID
- id_rs1_used, id_rs2_used  in  1  instruction in ID reads rs1 / rs2
- ex_rd_idx  in  IDX_W  destination index of the instruction in EX
- ex_is_load, ex_wben  in  1  EX instruction is a load / writes back
- ex_div_en  in  1  EX instruction is a div/rem (DivEn of the EX register)
- div_done  in  1  divider result valid; held until the next div_start
- ex_redirect  in  1  taken branch or jump resolved in EX
- mem_busy  in  1  LSU cannot accept or complete this cycle
- pc_hold, id_hold, ex_hold, mem_hold  out  1  register keeps its contents
- ex_stall_n, mem_stall_n, wb_stall_n  out  1  low: load a bubble into that register
- id_flush, ex_flush  out  1  squash IF/ID and ID/EX contents
- div_start  out  1  one-cycle start pulse to the divider
- div_busy  out  1  FSM in DIV_BUSY or DIV_DONE
- div_timeout  out  1  sticky error flag
- stall_cycles  out  CNT_W  count of cycles with pc_hold=1

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to DIV_IDLE; div counter, stall_cycles and div_timeout clear.
  - All hold, flush and div_start outputs read 0; all *_stall_n read 1.
  - Reset mid-divide abandons the operation; no div_start pulse is produced.
- Control outputs are combinational from inputs and state. FSM and counters are registered.
- Priority, highest first: mem_busy > divide > redirect > load-use. Only the highest active source drives the outputs.
- mem_busy=1:
  - pc_hold, id_hold, ex_hold and mem_hold are 1; wb_stall_n=0.
  - Flushes are suppressed. A redirect stays asserted by its still-held EX instruction and is honoured later.
- Divide FSM states: DIV_IDLE, DIV_BUSY, DIV_DONE.
  - DIV_IDLE: ex_div_en=1 and mem_busy=0 gives div_start=1 this cycle, next state DIV_BUSY, and asserts pc_hold/id_hold/ex_hold with mem_stall_n=0. div_done is ignored in DIV_IDLE.
  - DIV_BUSY: pc_hold/id_hold/ex_hold=1 and mem_stall_n=0. The div counter increments, saturating at 2^8-1. div_done=1 moves to DIV_DONE.
  - div_timeout sets when the counter reaches DIV_TIMEOUT and stays set until rst.
  - DIV_DONE: no divide holds, so EX advances with the result. Next state DIV_IDLE, unless mem_busy=1, in which case it stays in DIV_DONE. ex_div_en is ignored here, so the same instruction is never restarted.
  - Back-to-back divides: a div entering EX after DIV_DONE starts a new operation from DIV_IDLE.
- Redirect (ex_redirect=1, no higher source): id_flush=1 and ex_flush=1 for that cycle; no holds.
- Load-use:
  - Hazard = ex_is_load & ex_wben & ex_rd_idx!=0 & ((id_rs1_used & id_rs1_idx==ex_rd_idx) | (id_rs2_used & id_rs2_idx==ex_rd_idx)).
  - Response: pc_hold=id_hold=1 and ex_stall_n=0 for exactly one cycle. The load advances, so the hazard drops the following cycle.
- Simultaneous redirect and load-use: the redirect wins. The dependent ID instruction is flushed and no hold is issued.
- x0 never causes a hazard.
- stall_cycles increments each cycle pc_hold=1 and wraps at 2^CNT_W.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - div FSM state enum, 2 bits: DIV_IDLE=0, DIV_BUSY=1, DIV_DONE=2
  - hazard-source priority constants
  - IDX_W default
- Sub-module load_use_detect: combinational comparator producing the single load-use hazard bit.
- FSM, priority mux and counters stay in pipe_hazard_ctrl.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 -> one cycle with pc_hold=id_hold=1 and ex_stall_n=0, then all released; rd=x0 with the same stimulus -> no stall.
- div in EX, div_done asserted 8 cycles after div_start -> div_start high 1 cycle; holds for 9 cycles (start cycle + 8 BUSY); DIV_DONE 1 cycle; back to IDLE; stall_cycles = 9.
- ex_redirect with a load-use hazard present -> id_flush=ex_flush=1 and pc_hold=0 in the same cycle.
- mem_busy for 3 cycles during DIV_DONE -> FSM stays in DIV_DONE 4 cycles total, wb_stall_n=0 for those 3 cycles, no second div_start.
- div_done withheld for 100 cycles -> div_timeout=1 at cycle 100 and stays set; rst=1 -> FSM in IDLE, div_timeout=0, stall_cycles=0.
- rst asserted in DIV_BUSY, then ex_div_en=1 -> a fresh div_start pulse follows in the first post-reset cycle.
